// File: rtl/sequence_controller_pkg.sv
// Shared types and default sizing for the step sequencer.
package sequence_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        RECORD = 2'd2,
        CLEAR  = 2'd3
    } state_e;

    localparam int DEF_STEP_TICKS = 6250000;
    localparam int DEF_ADDR_W     = 6;
    localparam int DEF_NOTE_W     = 10;

endpackage

// File: rtl/sequence_controller_step_timer.sv
// Step-period down-counter: holds STEP_TICKS-1 while loading, strobes tick_o on reaching zero.
module step_timer
    import sequence_controller_pkg::*;
#(
    parameter int STEP_TICKS = DEF_STEP_TICKS
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (enable_i) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = enable_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/sequence_controller.sv
// Bank-switched step sequencer: play, record and clear against an external sync-read RAM.
// Define SEQ_LOOP_EN to make PLAY wrap from the last step back to step 0 until stopped.
module sequence_controller
    import sequence_controller_pkg::*;
#(
    parameter int STEP_TICKS = DEF_STEP_TICKS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int BANK_W     = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     play_req,
    input  logic                     rec_req,
    input  logic                     clear_req,
    input  logic                     stop,
    input  logic [BANK_W-1:0]        bank_sel,
    input  logic [NOTE_W-1:0]        key_gates,
    input  logic [NOTE_W-1:0]        ram_q,
    output logic [BANK_W+ADDR_W-1:0] ram_addr,
    output logic [NOTE_W-1:0]        ram_data,
    output logic                     ram_wren,
    output logic [NOTE_W-1:0]        note_gates,
    output logic                     step_pulse,
    output logic                     busy,
    output logic [1:0]               state
);

    localparam logic [ADDR_W-1:0] LAST_STEP = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   step_q, step_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [NOTE_W-1:0]   acc_q, acc_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                running;
    logic                tick;

    assign running = (state_q == PLAY) || (state_q == RECORD);

    step_timer #(.STEP_TICKS(STEP_TICKS)) u_step_timer (
        .clock   (clock),
        .reset   (reset),
        .load_i  (!running),
        .enable_i(running),
        .tick_o  (tick)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        bank_d     = bank_q;
        acc_d      = acc_q;
        note_d     = '0;
        ram_wren   = 1'b0;
        ram_data   = '0;
        note_gates = '0;
        case (state_q)
            IDLE: begin
                step_d = '0;
                acc_d  = '0;
                if (clear_req) begin
                    state_d = CLEAR;
                    bank_d  = bank_sel;
                end else if (rec_req) begin
                    state_d = RECORD;
                    bank_d  = bank_sel;
                end else if (play_req) begin
                    state_d = PLAY;
                    bank_d  = bank_sel;
                end
            end
            PLAY: begin
                // RAM data lags the address by one clock; registering it again gives the 2-clock alignment
                note_d     = ram_q;
                note_gates = note_q;
                if (tick) begin
                    step_d = step_q + 1'b1;
`ifdef SEQ_LOOP_EN
`else
                    if (step_q == LAST_STEP) begin
                        state_d = IDLE;
                        step_d  = '0;
                    end
`endif
                end
            end
            RECORD: begin
                note_gates = key_gates;
                acc_d      = acc_q | key_gates;
                if (tick) begin
                    ram_wren = 1'b1;
                    ram_data = acc_q | key_gates;
                    acc_d    = '0;
                    step_d   = step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        state_d = IDLE;
                        step_d  = '0;
                    end
                end
            end
            CLEAR: begin
                ram_wren = 1'b1;
                step_d   = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = IDLE;
                    step_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // stop aborts everything, including a write that would land on this boundary
        if (stop) begin
            state_d  = IDLE;
            step_d   = '0;
            acc_d    = '0;
            note_d   = '0;
            ram_wren = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            bank_q  <= '0;
            acc_q   <= '0;
            note_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            bank_q  <= bank_d;
            acc_q   <= acc_d;
            note_q  <= note_d;
        end
    end

    assign ram_addr   = {bank_q, step_q};
    assign step_pulse = tick;
    assign busy       = (state_q != IDLE);
    assign state      = state_q;

endmodule
